// File: rtl/unified_mem_ctrl.sv
// unified_mem_ctrl: shared instr/data single-port memory with round-robin arbitration, wait states, byte enables and range errors
module unified_mem_ctrl #(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [XLEN-1:0]   i_addr,
    output logic              i_ready,
    output logic [XLEN-1:0]   i_rdata,
    output logic              i_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [XLEN/8-1:0] d_be,
    input  logic [XLEN-1:0]   d_addr,
    input  logic [XLEN-1:0]   d_wdata,
    output logic              d_ready,
    output logic [XLEN-1:0]   d_rdata,
    output logic              d_err,
    output logic              busy
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int BW = XLEN / 8;
    localparam logic [XLEN-1:0] LIMIT = XLEN'(4 * DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES == 0 ? 0 : WAIT_STATES - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              src_q, src_d;
    logic              last_q, last_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic              we_q, we_d;
    logic [BW-1:0]     be_q, be_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [XLEN-1:0]   i_rdata_q, i_rdata_d;
    logic [XLEN-1:0]   d_rdata_q, d_rdata_d;
    logic              err_q, err_d;
    logic [XLEN-1:0]   mem [DEPTH_WORDS];
    logic [AW-1:0]     idx;
    logic              oor;
    logic              grant_d;
    logic              unused_addr;

    assign idx         = addr_q[AW+1:2];
    assign oor         = addr_q >= LIMIT;
    assign unused_addr = ^addr_q[1:0];
    // src/last encoding: 0 = instruction port, 1 = data port
    assign grant_d     = d_req && (!i_req || !last_q);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        src_d     = src_q;
        last_d    = last_q;
        addr_d    = addr_q;
        we_d      = we_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        err_d     = err_q;
        case (state_q)
            S_IDLE: if (i_req || d_req) begin
                src_d   = grant_d;
                last_d  = grant_d;
                addr_d  = grant_d ? d_addr : i_addr;
                we_d    = grant_d && d_we;
                be_d    = d_be;
                wdata_d = d_wdata;
                cnt_d   = CNT_INIT;
                state_d = WAIT_STATES > 0 ? S_WAIT : S_ACCESS;
            end
            S_WAIT: begin
                cnt_d   = cnt_q - 4'd1;
                state_d = cnt_q == 4'd0 ? S_ACCESS : S_WAIT;
            end
            S_ACCESS: begin
                err_d = oor;
                if (!src_q) i_rdata_d = oor ? '0 : mem[idx];
                else if (!we_q) d_rdata_d = oor ? '0 : mem[idx];
                state_d = S_RESP;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            src_q     <= 1'b0;
            last_q    <= 1'b0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            be_q      <= '0;
            wdata_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            src_q     <= src_d;
            last_q    <= last_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            err_q     <= err_d;
        end
    end

    // Array has no reset; an aborting reset drops state to IDLE so no write fires.
    always_ff @(posedge clk) begin
        if (state_q == S_ACCESS && we_q && !oor)
            for (int k = 0; k < BW; k++)
                if (be_q[k]) mem[idx][8*k +: 8] <= wdata_q[8*k +: 8];
    end

    assign busy    = state_q != S_IDLE;
    assign i_ready = state_q == S_RESP && !src_q;
    assign d_ready = state_q == S_RESP && src_q;
    assign i_err   = i_ready && err_q;
    assign d_err   = d_ready && err_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;
endmodule

// File: tb/tb_unified_mem_ctrl.sv
// tb_unified_mem_ctrl: directed checks of unified_mem_ctrl; three instances (WAIT_STATES 1, 0, 15) share the stimulus
module tb_unified_mem_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [3:0]  d_be = '0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [2:0]  i_rdy, i_er, d_rdy, d_er, bsy;
    logic [31:0] i_rd [3];
    logic [31:0] d_rd [3];
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    unified_mem_ctrl #(.XLEN(32), .DEPTH_WORDS(256), .WAIT_STATES(1)) u_ws1 (
        .clk(clk), .reset(reset), .i_req(i_req), .i_addr(i_addr),
        .i_ready(i_rdy[0]), .i_rdata(i_rd[0]), .i_err(i_er[0]),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_rdy[0]), .d_rdata(d_rd[0]), .d_err(d_er[0]), .busy(bsy[0]));
    unified_mem_ctrl #(.XLEN(32), .DEPTH_WORDS(256), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .reset(reset), .i_req(i_req), .i_addr(i_addr),
        .i_ready(i_rdy[1]), .i_rdata(i_rd[1]), .i_err(i_er[1]),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_rdy[1]), .d_rdata(d_rd[1]), .d_err(d_er[1]), .busy(bsy[1]));
    unified_mem_ctrl #(.XLEN(32), .DEPTH_WORDS(256), .WAIT_STATES(15)) u_ws15 (
        .clk(clk), .reset(reset), .i_req(i_req), .i_addr(i_addr),
        .i_ready(i_rdy[2]), .i_rdata(i_rd[2]), .i_err(i_er[2]),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_rdy[2]), .d_rdata(d_rd[2]), .d_err(d_er[2]), .busy(bsy[2]));

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Data access on the WAIT_STATES=1 instance; starts and ends at a negedge with the DUT idle.
    task automatic d_xact(input logic we, input logic [3:0] be, input logic [31:0] addr,
                          input logic [31:0] wd, output logic ok, output logic [31:0] rd,
                          output logic er);
        d_req = 1'b1; d_we = we; d_be = be; d_addr = addr; d_wdata = wd;
        ok = 1'b0; rd = '0; er = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            if (d_rdy[0]) begin ok = 1'b1; rd = d_rd[0]; er = d_er[0]; end
        end
        d_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        vec_t        tbl [13];
        logic        ok, er, seen;
        logic [31:0] rd;
        int          lat [3];
        logic [31:0] lrd [3];
        int          exp_lat [3];

        tbl[0]  = '{1'b1, 4'hF, 32'h10,       32'hAABBCCDD, 32'h0,        1'b0};
        tbl[1]  = '{1'b1, 4'h5, 32'h10,       32'h11223344, 32'h0,        1'b0};
        tbl[2]  = '{1'b0, 4'h0, 32'h10,       32'h0,        32'hAA22CC44, 1'b0};
        tbl[3]  = '{1'b1, 4'hF, 32'h0C,       32'hDEADBEEF, 32'hAA22CC44, 1'b0};
        tbl[4]  = '{1'b1, 4'hF, 32'h20,       32'h12345678, 32'hAA22CC44, 1'b0};
        tbl[5]  = '{1'b1, 4'hF, 32'h00,       32'hCAFEF00D, 32'hAA22CC44, 1'b0};
        tbl[6]  = '{1'b0, 4'h0, 32'h400,      32'h0,        32'h0,        1'b1};
        tbl[7]  = '{1'b1, 4'hF, 32'h400,      32'hFFFFFFFF, 32'h0,        1'b1};
        tbl[8]  = '{1'b0, 4'h0, 32'h00,       32'h0,        32'hCAFEF00D, 1'b0};
        tbl[9]  = '{1'b0, 4'h0, 32'h13,       32'h0,        32'hAA22CC44, 1'b0};
        tbl[10] = '{1'b1, 4'h0, 32'h20,       32'h0,        32'hAA22CC44, 1'b0};
        tbl[11] = '{1'b0, 4'h0, 32'h20,       32'h0,        32'h12345678, 1'b0};
        tbl[12] = '{1'b0, 4'h0, 32'hFFFFFFFC, 32'h0,        32'h0,        1'b1};

        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bsy), 32'h0);
        chk("rst_ready", 32'({i_rdy[0], d_rdy[0]}), 32'h0);
        chk("rst_err", 32'({i_er[0], d_er[0]}), 32'h0);
        chk("rst_i_rdata", i_rd[0], 32'h0);
        chk("rst_d_rdata", d_rd[0], 32'h0);
        reset = 1'b1;
        @(negedge clk);

        foreach (tbl[v]) begin
            d_xact(tbl[v].we, tbl[v].be, tbl[v].addr, tbl[v].wdata, ok, rd, er);
            chk($sformatf("vec%0d_ready", v), 32'(ok), 32'h1);
            chk($sformatf("vec%0d_rdata", v), rd, tbl[v].exp_rd);
            chk($sformatf("vec%0d_err", v), 32'(er), 32'(tbl[v].exp_err));
        end

        // Fetch latency with one wait state: ready in cycle 3, busy cycles 1..3.
        i_req = 1'b1; i_addr = 32'h0C;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            chk($sformatf("fetch_c%0d_ready", n), 32'(i_rdy[0]), 32'(n == 3));
            chk($sformatf("fetch_c%0d_busy", n), 32'(bsy[0]), 32'(n <= 3));
            if (n == 3) begin
                chk("fetch_rdata", i_rd[0], 32'hDEADBEEF);
                chk("fetch_err", 32'(i_er[0]), 32'h0);
                i_req = 1'b0;
            end
        end

        // Both ports held across reset release: data, instr, data, instr.
        reset = 1'b0;
        i_req = 1'b1; i_addr = 32'h0C;
        d_req = 1'b1; d_we = 1'b0; d_be = 4'h0; d_addr = 32'h10;
        @(negedge clk);
        reset = 1'b1;
        for (int g = 0; g < 4; g++) begin
            seen = 1'b0;
            for (int n = 0; n < 12 && !seen; n++) begin
                @(negedge clk);
                seen = i_rdy[0] | d_rdy[0];
            end
            chk($sformatf("arb%0d_seen", g), 32'(seen), 32'h1);
            chk($sformatf("arb%0d_excl", g), 32'(i_rdy[0] & d_rdy[0]), 32'h0);
            chk($sformatf("arb%0d_port_is_data", g), 32'(d_rdy[0]), 32'(g % 2 == 0));
            if (d_rdy[0]) chk($sformatf("arb%0d_d_rdata", g), d_rd[0], 32'hAA22CC44);
            else chk($sformatf("arb%0d_i_rdata", g), i_rd[0], 32'hDEADBEEF);
        end
        i_req = 1'b0; d_req = 1'b0;
        @(negedge clk);

        // Reset during WAIT of a store aborts it.
        d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 32'h20; d_wdata = 32'h55555555;
        @(negedge clk);
        chk("abort_busy_in_wait", 32'(bsy[0]), 32'h1);
        #2 reset = 1'b0;
        #1;
        chk("abort_busy", 32'(bsy[0]), 32'h0);
        chk("abort_ready", 32'(d_rdy[0]), 32'h0);
        chk("abort_d_rdata", d_rd[0], 32'h0);
        chk("abort_i_rdata", i_rd[0], 32'h0);
        d_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | d_rdy[0];
        end
        chk("abort_no_ready", 32'(seen), 32'h0);
        d_xact(1'b0, 4'h0, 32'h20, 32'h0, ok, rd, er);
        chk("abort_reload_ready", 32'(ok), 32'h1);
        chk("abort_word8", rd, 32'h12345678);

        // Latency of all three instances; fields toggle after acceptance.
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 32'h40; d_wdata = 32'h0BADF00D;
        @(negedge clk);
        d_req = 1'b0;
        repeat (20) @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
        lat = '{0, 0, 0};
        lrd = '{32'h0, 32'h0, 32'h0};
        exp_lat = '{3, 2, 17};
        for (int n = 1; n <= 25; n++) begin
            @(negedge clk);
            if (n == 1) begin
                d_req = 1'b0; d_we = 1'b1; d_addr = 32'h44; d_wdata = 32'h0; d_be = 4'hF;
            end
            for (int j = 0; j < 3; j++)
                if (lat[j] == 0 && d_rdy[j]) begin
                    lat[j] = n;
                    lrd[j] = d_rd[j];
                end
        end
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("lat_inst%0d", j), 32'(lat[j]), 32'(exp_lat[j]));
            chk($sformatf("lat_rdata_inst%0d", j), lrd[j], 32'h0BADF00D);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
